// File: rtl/fetch_queue_if.sv
// Fetch-queue handshake bundle: redirect, instruction-memory request/response and decode-side dequeue.
interface fetch_queue_if #(
    parameter int unsigned INST_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 4
);
    logic                         redirect;
    logic [ADDR_W-1:0]            redirect_pc;
    logic                         mem_req;
    logic [ADDR_W-1:0]            mem_addr;
    logic                         mem_rsp_valid;
    logic [INST_W-1:0]            mem_rsp_data;
    logic                         deq_valid;
    logic [INST_W-1:0]            deq_inst;
    logic [ADDR_W-1:0]            deq_pc;
    logic                         deq_ready;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        input  redirect, redirect_pc, mem_rsp_valid, mem_rsp_data, deq_ready,
        output mem_req, mem_addr, deq_valid, deq_inst, deq_pc, count
    );

    modport slave (
        output redirect, redirect_pc, mem_rsp_valid, mem_rsp_data, deq_ready,
        input  mem_req, mem_addr, deq_valid, deq_inst, deq_pc, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one outstanding memory request, responses buffered in a DEPTH-entry FIFO.
// Issue stalls while the queue would be full; FETCH_QUEUE_BYPASS_EN forwards a response to deq_* when empty.
module fetch_queue #(
    parameter int unsigned INST_W   = 16,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned PC_INC   = 2
) (
    input logic            clk,
    input logic            rst,
    fetch_queue_if.master  fq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, SQUASH = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]   req_pc_q, req_pc_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d, count_nr;
    logic [INST_W-1:0]   ent_inst_q [DEPTH];
    logic [ADDR_W-1:0]   ent_pc_q   [DEPTH];

    logic                q_empty, rsp_acc, bypass_vld, bypass_take;
    logic                head_vld, deq_fire, wr_en, rd_adv, issue;
    logic [INST_W-1:0]   head_inst;
    logic [ADDR_W-1:0]   head_pc;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        q_empty = (count_q == '0);
        rsp_acc = (state_q == BUSY) && fq.mem_rsp_valid && !fq.redirect;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_vld = q_empty && rsp_acc;
`else
        bypass_vld = 1'b0;
`endif
        head_vld    = !q_empty || bypass_vld;
        head_inst   = q_empty ? fq.mem_rsp_data : ent_inst_q[rd_ptr_q];
        head_pc     = q_empty ? req_pc_q : ent_pc_q[rd_ptr_q];
        deq_fire    = head_vld && fq.deq_ready && !fq.redirect;
        // A bypassed response that is consumed this cycle never touches the storage.
        bypass_take = bypass_vld && deq_fire;
        wr_en       = rsp_acc && !bypass_take;
        rd_adv      = deq_fire && !bypass_take;
        count_nr    = count_q + CNT_W'(wr_en) - CNT_W'(rd_adv);
        issue       = !fq.redirect
                      && ((state_q == IDLE) || ((state_q == BUSY) && fq.mem_rsp_valid))
                      && (count_nr < CNT_W'(DEPTH));
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        wr_ptr_d   = wr_en  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = rd_adv ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d    = count_nr;
        if (issue) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INC);
            req_pc_d   = fetch_pc_q;
        end
        case (state_q)
            IDLE:    if (issue) state_d = BUSY;
            BUSY: begin
                if (fq.redirect)           state_d = fq.mem_rsp_valid ? IDLE : SQUASH;
                else if (fq.mem_rsp_valid) state_d = issue ? BUSY : IDLE;
            end
            SQUASH:  if (fq.mem_rsp_valid && !fq.redirect) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (fq.redirect) begin
            fetch_pc_d = fq.redirect_pc;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= ADDR_W'(RESET_PC);
            req_pc_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ent_inst_q[wr_ptr_q] <= fq.mem_rsp_data;
            ent_pc_q[wr_ptr_q]   <= req_pc_q;
        end
    end

    // Outputs are gated so reset forces them to zero without waiting for a clock edge.
    assign fq.mem_req   = issue && !rst;
    assign fq.mem_addr  = fq.mem_req ? fetch_pc_q : '0;
    assign fq.deq_valid = head_vld;
    assign fq.deq_inst  = head_vld ? head_inst : '0;
    assign fq.deq_pc    = head_vld ? head_pc : '0;
    assign fq.count     = count_q;
endmodule
